// File: rtl/hc_sr04_ranger_ctrl.sv
// HC-SR04 ultrasonic ranger sequencer: periodic trigger, echo synchroniser,
// echo-width measurement in clk ticks, and timeout flagging.
module hc_sr04_ranger_ctrl #(
  parameter int TRIG_TICKS    = 500,
  parameter int PERIOD_TICKS  = 3000000,
  parameter int TIMEOUT_TICKS = 1500000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [20:0] ticks_20ns,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int PER_W = $clog2(PERIOD_TICKS + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;

  localparam logic [20:0]      TRIG_LAST = 21'(TRIG_TICKS - 1);
  localparam logic [20:0]      TO_LAST   = 21'(TIMEOUT_TICKS - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   echo_d_reg;
  logic                   echo_s;
  logic                   rise;
  logic                   fall;

  logic [2:0]       state_reg, state_next;
  logic [PER_W-1:0] per_cnt_reg, per_cnt_next;
  logic [20:0]      ph_cnt_reg, ph_cnt_next;
  logic [20:0]      width_reg, width_next;
  logic [20:0]      ticks_reg, ticks_next;
  logic             trig_reg, trig_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;
  logic             busy_reg, busy_next;

  assign echo_s = sync_reg[SYNC_STAGES-1];
  assign rise   = echo_s & ~echo_d_reg;
  assign fall   = ~echo_s & echo_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= '0;
      echo_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], echo};
      echo_d_reg <= echo_s;
    end
  end

  always_comb begin
    state_next   = state_reg;
    trig_next    = trig_reg;
    width_next   = width_reg;
    ticks_next   = ticks_reg;
    valid_next   = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = TRIG;
          trig_next  = 1'b1;
        end
      end
      TRIG: begin
        if (ph_cnt_reg == TRIG_LAST) begin
          state_next = WAIT_RISE;
          trig_next  = 1'b0;
        end
      end
      WAIT_RISE: begin
        // Only a genuine edge starts a measurement; a level already high is stale.
        if (rise) begin
          state_next = MEASURE;
          width_next = 21'd1;
        end else if (ph_cnt_reg == TO_LAST) begin
          state_next   = HOLDOFF;
          timeout_next = 1'b1;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_next = HOLDOFF;
          ticks_next = width_reg;
          valid_next = 1'b1;
        end else begin
          width_next = width_reg + 21'd1;
          if (width_reg == TO_LAST) begin
            state_next   = HOLDOFF;
            timeout_next = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        // A live echo keeps us here so the next trigger never overlaps it.
        if (per_cnt_reg >= PER_LAST && !echo_s) begin
          if (enable) begin
            state_next = TRIG;
            trig_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        trig_next  = 1'b0;
      end
    endcase
  end

  always_comb begin
    per_cnt_next = per_cnt_reg;
    if (state_next == TRIG && state_reg != TRIG)
      per_cnt_next = '0;
    else if (state_reg != IDLE && per_cnt_reg != '1)
      per_cnt_next = per_cnt_reg + 1'b1;

    ph_cnt_next = ph_cnt_reg;
    if (state_next != state_reg)
      ph_cnt_next = '0;
    else if (ph_cnt_reg != '1)
      ph_cnt_next = ph_cnt_reg + 21'd1;

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      per_cnt_reg <= '0;
      ph_cnt_reg  <= '0;
      width_reg   <= '0;
      ticks_reg   <= '0;
      trig_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      per_cnt_reg <= per_cnt_next;
      ph_cnt_reg  <= ph_cnt_next;
      width_reg   <= width_next;
      ticks_reg   <= ticks_next;
      trig_reg    <= trig_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      busy_reg    <= busy_next;
    end
  end

  assign trig       = trig_reg;
  assign ticks_20ns = ticks_reg;
  assign valid      = valid_reg;
  assign timeout    = timeout_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_hc_sr04_ranger_ctrl.sv
// Directed bench for hc_sr04_ranger_ctrl with time constants scaled down
// (trig 5, period 300, timeout 100) so whole measurement cycles fit in a short run.
module tb_hc_sr04_ranger_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [20:0] ticks_20ns;
  logic        valid;
  logic        timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int both_cnt  = 0;

  hc_sr04_ranger_ctrl #(
    .TRIG_TICKS   (5),
    .PERIOD_TICKS (300),
    .TIMEOUT_TICKS(100),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .ticks_20ns(ticks_20ns),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (valid === 1'b1 && timeout === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %-20s observed=%0d expected=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sel: 0 trig, 1 valid, 2 timeout, 3 busy
  task automatic wait_sig(input int sel, input logic val, input int bound, input string tag,
                          output int t_seen);
    int  n;
    bit  done;
    logic s;
    n = 0;
    done = 1'b0;
    t_seen = -1;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       s = trig;
        1:       s = valid;
        2:       s = timeout;
        default: s = busy;
      endcase
      if (s === val) begin
        done = 1'b1;
        t_seen = cyc;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL wait_%s observed=no event expected=event within %0d cycles", tag, bound);
    end
  endtask

  task automatic measure_trig_high(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (trig === 1'b1 && n < 1000) begin
      n++;
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
    end
  endtask

  initial begin
    int t_r1, t_r2, t_r3, t_r4, t_r6;
    int t_fall, t_drop, t_v, t_to, t_e, t_b, c_en, c_rel;
    int n_hi, n_bl, cnt_a, cnt_b, v0;

    rst_n  = 1'b0;
    enable = 1'b0;
    echo   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trig), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_ticks", 32'(ticks_20ns), 0);

    // 1: first trigger pulse
    rst_n  = 1'b1;
    enable = 1'b1;
    c_en   = cyc;
    wait_sig(0, 1'b1, 5, "trig1", t_r1);
    check("trig1_latency", 32'(t_r1 - c_en), 1);
    measure_trig_high(n_hi, n_bl);
    check("trig1_width", 32'(n_hi), 5);
    check("trig1_busy_low", 32'(n_bl), 0);
    t_fall = cyc;

    // 2: 40-cycle echo
    echo = 1'b1;
    repeat (40) @(negedge clk);
    echo = 1'b0;
    t_drop = cyc;
    wait_sig(1, 1'b1, 20, "valid1", t_v);
    check("valid1_latency", 32'(t_v - t_drop), 3);
    check("valid1_ticks", 32'(ticks_20ns), 40);
    check("valid1_no_timeout", 32'(timeout), 0);
    @(negedge clk);
    check("valid1_one_cycle", 32'(valid), 0);
    wait_sig(0, 1'b1, 400, "trig2", t_r2);
    check("period_1", 32'(t_r2 - t_r1), 300);

    // 3: no echo at all
    measure_trig_high(n_hi, n_bl);
    check("trig2_width", 32'(n_hi), 5);
    t_fall = cyc;
    v0 = valid_cnt;
    wait_sig(2, 1'b1, 150, "timeout1", t_to);
    check("timeout1_delay", 32'(t_to - t_fall), 100);
    check("timeout1_ticks_held", 32'(ticks_20ns), 40);
    check("timeout1_no_valid", 32'(valid_cnt - v0), 0);
    @(negedge clk);
    check("timeout1_one_cycle", 32'(timeout), 0);
    wait_sig(0, 1'b1, 400, "trig3", t_r3);
    check("period_2", 32'(t_r3 - t_r2), 300);

    // 4: echo stuck high past timeout and past the period end
    measure_trig_high(n_hi, n_bl);
    t_e = cyc;
    echo = 1'b1;
    wait_sig(2, 1'b1, 150, "timeout2", t_to);
    check("timeout2_width", 32'(t_to - t_e), 102);
    check("timeout2_ticks_held", 32'(ticks_20ns), 40);
    cnt_a = 0;
    while (cyc < t_e + 350) begin
      @(negedge clk);
      if (trig === 1'b1) cnt_a++;
    end
    echo = 1'b0;
    t_drop = cyc;
    check("holdoff_no_retrig", 32'(cnt_a), 0);
    wait_sig(0, 1'b1, 20, "trig4", t_r4);
    check("holdoff_stretch", 32'(t_r4 - t_drop), 3);

    // 5: enable dropped mid-measurement of an 80-cycle echo
    measure_trig_high(n_hi, n_bl);
    check("trig4_width", 32'(n_hi), 5);
    echo = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (70) @(negedge clk);
    echo = 1'b0;
    wait_sig(1, 1'b1, 20, "valid2", t_v);
    check("valid2_ticks", 32'(ticks_20ns), 80);
    wait_sig(3, 1'b0, 400, "idle", t_b);
    check("idle_at_period_end", 32'(t_b - t_r4), 300);
    cnt_a = 0;
    cnt_b = 0;
    repeat (400) begin
      @(negedge clk);
      if (trig === 1'b1) cnt_a++;
      if (busy === 1'b1) cnt_b++;
    end
    check("idle_no_trig", 32'(cnt_a), 0);
    check("idle_no_busy", 32'(cnt_b), 0);

    // 6: asynchronous reset in the middle of a trigger pulse
    enable = 1'b1;
    c_en = cyc;
    wait_sig(0, 1'b1, 5, "trig5", t_r6);
    check("trig5_latency", 32'(t_r6 - c_en), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_trig", 32'(trig), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ticks", 32'(ticks_20ns), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_timeout", 32'(timeout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c_rel = cyc;
    wait_sig(0, 1'b1, 5, "trig6", t_r6);
    check("trig6_latency", 32'(t_r6 - c_rel), 1);
    measure_trig_high(n_hi, n_bl);
    check("trig6_width", 32'(n_hi), 5);

    check("strobes_exclusive", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
